// File: rtl/apu_pkg.sv
// Shared APU definitions: channel frequency width/type and CPU register addresses.
package apu_pkg;

  localparam int CH_FREQ_W = 11;

  typedef logic [CH_FREQ_W-1:0] ch_freq_t;

  localparam logic [15:0] FF13_ADDR = 16'hFF13;
  localparam logic [15:0] FF14_ADDR = 16'hFF14;

endpackage

// File: rtl/ch_freq_counter.sv
// Channel period counter: reloads from the frequency value, counts up on enable,
// and emits a registered one-cycle wrap pulse when it rolls over from all-ones.
module ch_freq_counter
  import apu_pkg::*;
#(
  parameter int W = CH_FREQ_W
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         reload,
  input  logic         enable,
  input  logic [W-1:0] reload_val,
  output logic         wrap
);

  logic [W-1:0] count_reg;
  logic         wrap_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      if (reload) begin
        count_reg <= reload_val;
      end else if (enable) begin
        // Reload on wrap so a new frequency only lands at a period boundary.
        if (&count_reg) begin
          count_reg <= reload_val;
          wrap_reg  <= 1'b1;
        end else begin
          count_reg <= count_reg + {{(W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign wrap = wrap_reg;

endmodule

// File: rtl/ch1_freq_sweep.sv
// Channel-1 frequency datapath: frequency register, sweep shadow shifter,
// sweep adder with overflow flag, and the period counter driving copu.
module ch1_freq_sweep
  import apu_pkg::*;
#(
  parameter int FREQ_W = CH_FREQ_W
) (
  input  logic              ajer_2mhz,
  input  logic              apu_reset,
  input  logic [7:0]        d,
  input  logic              apu_wr,
  input  logic              ff13,
  input  logic              ff14,
  input  logic              sweep_negate,
  input  logic              ch1_restart,
  input  logic              ch1_ld_shift,
  input  logic              ch1_shift_clk,
  input  logic              ch1_freq_upd1,
  input  logic              ch1_freq_upd2,
  input  logic              freq_clk_en,
  output logic [FREQ_W-1:0] ch1_freq,
  output logic              atys,
  output logic              copu
);

  logic [FREQ_W-1:0] freq_reg;
  logic [FREQ_W-1:0] shift_reg;
  logic              atys_reg;
  logic [FREQ_W:0]   sum;
  logic              overflow;
  logic              cpu_wr_lo;
  logic              cpu_wr_hi;

  assign cpu_wr_lo = apu_wr && ff13;
  assign cpu_wr_hi = apu_wr && ff14;

  always_comb begin
    if (sweep_negate) begin
      sum = {1'b0, freq_reg} - {1'b0, shift_reg};
    end else begin
      sum = {1'b0, freq_reg} + {1'b0, shift_reg};
    end
  end

  // A borrow while subtracting just wraps; only a carry in add mode overflows.
  assign overflow = !sweep_negate && sum[FREQ_W];

  always_ff @(posedge ajer_2mhz) begin
    if (apu_reset) begin
      freq_reg  <= '0;
      shift_reg <= '0;
      atys_reg  <= 1'b1;
    end else begin
      if (cpu_wr_lo || cpu_wr_hi) begin
        if (cpu_wr_lo) freq_reg[7:0] <= d;
        if (cpu_wr_hi) freq_reg[FREQ_W-1:8] <= d[FREQ_W-9:0];
      end else if (ch1_freq_upd1 && !overflow) begin
        freq_reg <= sum[FREQ_W-1:0];
      end

      if (!ch1_restart) begin
        if (ch1_ld_shift) begin
          shift_reg <= freq_reg;
        end else if (ch1_shift_clk) begin
          shift_reg <= {1'b0, shift_reg[FREQ_W-1:1]};
        end
      end

      if (ch1_restart) begin
        atys_reg <= 1'b1;
      end else if ((ch1_freq_upd1 || ch1_freq_upd2) && overflow) begin
        atys_reg <= 1'b0;
      end
    end
  end

  ch_freq_counter #(
    .W(FREQ_W)
  ) u_period (
    .clk        (ajer_2mhz),
    .srst       (apu_reset),
    .reload     (ch1_restart),
    .enable     (freq_clk_en),
    .reload_val (freq_reg),
    .wrap       (copu)
  );

  assign ch1_freq = freq_reg;
  assign atys     = atys_reg;

endmodule
